spi_ram_ctrl: RTL

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

---
 rtl/spi_ram_ctrl_pkg.sv | 20 ++
 rtl/spi_ram_mem.sv | 32 +++
 rtl/spi_ram_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/spi_ram_ctrl_pkg.sv
// rtl/spi_ram_ctrl_pkg.sv - shared opcodes and FSM encodings for the SPI RAM controller
// Purpose: opcode constants and state encodings reused by the controller, SPI slave and bench.
// Contents: OP_* opcode constants, state_t FSM encoding, opcode_of() field extractor.
package spi_ram_ctrl_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TX   = 1'b1
  } state_t;

  function automatic logic [1:0] opcode_of(input logic [9:0] word);
    return word[9:8];
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// rtl/spi_ram_mem.sv - single-port RAM, synchronous write, combinational read
// Purpose: byte storage for the SPI RAM controller. Contents are never reset.
// Ports:
//   clk  - write clock
//   we   - write enable, din stored at addr on the rising edge
//   addr - shared read/write address
//   din  - write data
//   dout - read data of addr, available in the same cycle
module spi_ram_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           din,
  output logic [7:0]           dout
);

  logic [7:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  // Read is combinational so the controller can register read data on the
  // same edge that decodes the read command.
  assign dout = mem[addr];

endmodule

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - command decoder and TX FSM between an SPI slave and a byte RAM
// Purpose: decodes 10-bit command words ({opcode, payload}) once per rx_valid rise,
//          writes/reads the RAM and presents read data to the SPI slave.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   rx_data  - command word, [9:8] opcode, [7:0] payload
//   rx_valid - level, high while rx_data holds a complete word
//   tx_data  - read data for the slave to shift out
//   tx_valid - tx_data valid, held until rx_valid falls
//   cmd_err  - one-cycle pulse when a command is rejected
module spi_ram_ctrl
  import spi_ram_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       cmd_err
);

  state_t                 state;
  logic                   rx_valid_d;
  logic [ADDR_SIZE-1:0]   wr_addr;
  logic [ADDR_SIZE-1:0]   rd_addr;
  logic                   wr_addr_ok;
  logic                   rd_addr_ok;

  logic                   cmd_stb;
  logic [1:0]             op;
  logic                   mem_we;
  logic [ADDR_SIZE-1:0]   mem_addr;
  logic [7:0]             mem_dout;

  // A held rx_valid level executes exactly once: only its rising edge decodes.
  assign cmd_stb  = rx_valid & ~rx_valid_d;
  assign op       = opcode_of(rx_data);
  assign mem_we   = cmd_stb && (state == ST_IDLE) && (op == OP_WR_DATA) && wr_addr_ok;
  assign mem_addr = (op == OP_WR_DATA) ? wr_addr : rd_addr;

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (rx_data[7:0]),
    .dout (mem_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rx_valid_d <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_addr_ok <= 1'b0;
      rd_addr_ok <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      cmd_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_stb) begin
            case (op)
              OP_WR_ADDR: begin
                wr_addr    <= rx_data[ADDR_SIZE-1:0];
                wr_addr_ok <= 1'b1;
              end
              OP_WR_DATA: begin
                // The RAM write itself is driven by mem_we.
                if (!wr_addr_ok) begin
                  cmd_err <= 1'b1;
                end
              end
              OP_RD_ADDR: begin
                rd_addr    <= rx_data[ADDR_SIZE-1:0];
                rd_addr_ok <= 1'b1;
              end
              default: begin
                // A read without a prior read address still answers, with zero.
                tx_data  <= rd_addr_ok ? mem_dout : 8'h00;
                cmd_err  <= ~rd_addr_ok;
                tx_valid <= 1'b1;
                state    <= ST_TX;
              end
            endcase
          end
        end
        ST_TX: begin
          // tx_data is held; the slave is still shifting while rx_valid is high.
          if (!rx_valid) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
